// File: rtl/ecc_serial_loader.sv
// Bit-serial ECC operand loader: mode header plus NCH lanes,
// collected into a double-buffered parallel word with valid/ready.
module ecc_serial_loader #(
  parameter int BIT    = 32,
  parameter int NCH    = 6,
  parameter int DW     = 1,
  parameter int MODE_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_mode,
  input  logic [NCH*DW-1:0]     i_data,
  input  logic                  i_ready,
  input  logic                  i_clr_ovr,
  output logic                  o_valid,
  output logic [MODE_W-1:0]     o_mode,
  output logic [NCH*BIT-1:0]    o_data,
  output logic                  o_busy,
  output logic                  o_abort,
  output logic                  o_overrun
);

  localparam int BEATS = BIT / DW;
  localparam int CMAX  = (BEATS > MODE_W) ? BEATS : MODE_W;
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } st_t;

  st_t               state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [MODE_W-1:0] mode_sh, mode_nx;
  logic [BIT-1:0]    shift [NCH];
  logic [NCH*BIT-1:0] sh_nx;
  logic              shift_en;
  logic              complete;
  logic              abort_nx;
  logic              load;
  logic              drop;

  // Each lane shifts its newest group in at the LSB end.
  always_comb begin
    sh_nx = '0;
    for (int k = 0; k < NCH; k++) begin
      sh_nx[k*BIT +: BIT] = BIT'({shift[k], i_data[k*DW +: DW]});
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mode_nx  = mode_sh;
    shift_en = 1'b0;
    complete = 1'b0;
    abort_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_valid) begin
          mode_nx = MODE_W'(i_mode);
          if (MODE_W == 1) begin
            state_nx = DATA;
            cnt_nx   = '0;
          end else begin
            state_nx = HDR;
            cnt_nx   = CW'(1);
          end
        end
      end
      HDR: begin
        if (!i_valid) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          abort_nx = 1'b1;
        end else begin
          mode_nx = MODE_W'({mode_sh, i_mode});
          if (cnt == CW'(MODE_W - 1)) begin
            state_nx = DATA;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      DATA: begin
        if (!i_valid) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          abort_nx = 1'b1;
        end else begin
          shift_en = 1'b1;
          if (cnt == CW'(BEATS - 1)) begin
            complete = 1'b1;
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // A held word leaving on this edge frees the buffer for the new one.
  assign load   = complete && (!o_valid || i_ready);
  assign drop   = complete && o_valid && !i_ready;
  assign o_busy = (state == HDR) || (state == DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mode_sh <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      mode_sh <= mode_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        shift[k] <= '0;
      end
    end else if (shift_en) begin
      for (int k = 0; k < NCH; k++) begin
        shift[k] <= sh_nx[k*BIT +: BIT];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid   <= 1'b0;
      o_mode    <= '0;
      o_data    <= '0;
      o_abort   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_abort <= abort_nx;
      if (load) begin
        o_valid <= 1'b1;
        o_mode  <= mode_sh;
        o_data  <= sh_nx;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (drop) begin
        o_overrun <= 1'b1;
      end else if (i_clr_ovr) begin
        o_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ecc_serial_loader.sv
// Bench for ecc_serial_loader: frame-level model checked each
// cycle, plus literal expectations on timing and payloads.
module tb_ecc_serial_loader;

  localparam int BIT   = 32;
  localparam int NCH   = 6;
  localparam int DW    = 1;
  localparam int MW    = 2;
  localparam int FRAME = MW + BIT / DW;
  localparam int W     = NCH * BIT;

  logic clk, rst;
  logic i_valid, i_mode, i_ready, i_clr_ovr;
  logic [NCH*DW-1:0] i_data;
  logic o_valid, o_busy, o_abort, o_overrun;
  logic [MW-1:0] o_mode;
  logic [W-1:0] o_data;

  logic v4, md4;
  logic [7:0] d4;
  logic ov4, ob4, oa4, oo4;
  logic [1:0] om4;
  logic [63:0] od4;

  ecc_serial_loader dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_mode(i_mode),
    .i_data(i_data), .i_ready(i_ready),
    .i_clr_ovr(i_clr_ovr),
    .o_valid(o_valid), .o_mode(o_mode),
    .o_data(o_data), .o_busy(o_busy),
    .o_abort(o_abort), .o_overrun(o_overrun)
  );

  ecc_serial_loader #(
    .BIT(32), .NCH(2), .DW(4), .MODE_W(2)
  ) dut4 (
    .clk(clk), .rst(rst),
    .i_valid(v4), .i_mode(md4),
    .i_data(d4), .i_ready(1'b1),
    .i_clr_ovr(1'b0),
    .o_valid(ov4), .o_mode(om4),
    .o_data(od4), .o_busy(ob4),
    .o_abort(oa4), .o_overrun(oo4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic         valid;
    logic         ovr;
    logic         abort;
    logic [MW-1:0] mode;
    logic [W-1:0] data;
    logic [7:0]   pos;
    logic [MW-1:0] amode;
    logic [W-1:0] acc;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(
    input mdl_t s, input logic v, input logic md,
    input logic [NCH*DW-1:0] d, input logic rdy,
    input logic clr);
    mdl_t n;
    logic cons, ld, st;
    n = s;
    cons = s.valid && rdy;
    ld = 1'b0;
    st = 1'b0;
    n.abort = 1'b0;
    if (v) begin
      if (s.pos < MW) begin
        n.amode = {s.amode[MW-2:0], md};
      end else begin
        for (int k = 0; k < NCH; k++) begin
          n.acc[k*BIT +: BIT] =
            (s.acc[k*BIT +: BIT] << DW) |
            BIT'(d[k*DW +: DW]);
        end
      end
      n.pos = s.pos + 8'd1;
      if (n.pos == FRAME) begin
        n.pos = '0;
        if (!s.valid || cons) begin
          ld = 1'b1;
          n.mode = n.amode;
          n.data = n.acc;
        end else begin
          st = 1'b1;
        end
      end
    end else if (s.pos != 0) begin
      n.abort = 1'b1;
      n.pos = '0;
    end
    n.valid = ld ? 1'b1 : (cons ? 1'b0 : s.valid);
    n.ovr = st ? 1'b1 : (clr ? 1'b0 : s.ovr);
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else m <= step(m, i_valid, i_mode, i_data,
                   i_ready, i_clr_ovr);
  end

  int n_chk;
  int n_fail;
  int ncyc;
  logic prev_v;
  int rises[$];

  task automatic check(input string nm,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check("m_valid", W'(o_valid), W'(m.valid));
    check("m_busy", W'(o_busy), W'(m.pos != 0));
    check("m_abort", W'(o_abort), W'(m.abort));
    check("m_ovr", W'(o_overrun), W'(m.ovr));
    check("m_mode", W'(o_mode), W'(m.mode));
    check("m_data", o_data, m.data);
    if (o_valid && !prev_v) rises.push_back(ncyc);
    prev_v = o_valid;
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_mode = 1'b0;
    i_data = '0;
    cyc();
  endtask

  task automatic send(input logic [MW-1:0] md,
                      input logic [W-1:0] p,
                      input int nb);
    logic [NCH*DW-1:0] dd;
    for (int b = 0; b < nb; b++) begin
      dd = '0;
      i_valid = 1'b1;
      if (b < MW) begin
        i_mode = md[MW-1-b];
      end else begin
        i_mode = 1'b0;
        for (int k = 0; k < NCH; k++) begin
          dd[k] = p[k*BIT + BIT-1-(b-MW)];
        end
      end
      i_data = dd;
      cyc();
    end
  endtask

  localparam logic [W-1:0] PA = {
    32'h80000001, 32'h9ABCDEF0, 32'h12345678,
    32'hFFFFFFFD, 32'h00000007, 32'h00000003};
  localparam logic [W-1:0] PB = {
    32'h0BADF00D, 32'hCAFEBABE, 32'h00000000,
    32'hFFFFFFFF, 32'h55555555, 32'hAAAAAAAA};
  localparam logic [W-1:0] PC = {
    32'h11111111, 32'h22222222, 32'h33333333,
    32'h44444444, 32'h55555555, 32'h66666666};

  logic [63:0] g4;

  initial begin
    n_chk = 0; n_fail = 0; ncyc = 0; prev_v = 1'b0;
    rst = 1'b1;
    i_valid = 1'b0; i_mode = 1'b0; i_data = '0;
    i_ready = 1'b1; i_clr_ovr = 1'b0;
    v4 = 1'b0; md4 = 1'b0; d4 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", W'(o_valid), '0);
    check("rst_busy", W'(o_busy), '0);
    check("rst_data", o_data, '0);
    rst = 1'b0;
    idle();

    send(2'b01, PA, FRAME);
    check("t1_valid", W'(o_valid), W'(1));
    check("t1_mode", W'(o_mode), W'(2'b01));
    check("t1_lane2", W'(o_data[64 +: 32]),
          W'(32'hFFFFFFFD));
    check("t1_lane5", W'(o_data[160 +: 32]),
          W'(32'h80000001));
    check("t1_data", o_data, PA);
    idle();
    check("t1_pulse", W'(o_valid), '0);

    send(2'b10, PB, MW + 10);
    idle();
    check("ab_pulse", W'(o_abort), W'(1));
    check("ab_busy", W'(o_busy), '0);
    idle();
    check("ab_end", W'(o_abort), '0);
    check("ab_noval", W'(o_valid), '0);

    rises.delete();
    send(2'b01, PA, FRAME);
    check("bb_a", o_data, PA);
    send(2'b11, PB, FRAME);
    check("bb_b", o_data, PB);
    check("bb_mode", W'(o_mode), W'(2'b11));
    idle();
    idle();
    check("bb_rises", W'(rises.size()), W'(2));
    if (rises.size() == 2)
      check("bb_gap", W'(rises[1] - rises[0]), W'(34));

    i_ready = 1'b0;
    send(2'b10, PA, FRAME);
    send(2'b01, PB, FRAME);
    check("ov_set", W'(o_overrun), W'(1));
    check("ov_hold", o_data, PA);
    check("ov_mode", W'(o_mode), W'(2'b10));
    i_valid = 1'b0;
    i_clr_ovr = 1'b1;
    cyc();
    check("ov_clr", W'(o_overrun), '0);
    i_clr_ovr = 1'b0;
    i_ready = 1'b1;
    cyc();
    check("ov_drain", W'(o_valid), '0);

    i_ready = 1'b0;
    send(2'b01, PA, FRAME);
    send(2'b10, PB, MW + 18);
    #2;
    rst = 1'b1;
    i_valid = 1'b0;
    #1;
    check("mr_valid", W'(o_valid), '0);
    check("mr_data", o_data, '0);
    check("mr_busy", W'(o_busy), '0);
    check("mr_mode", W'(o_mode), '0);
    cyc();
    rst = 1'b0;
    i_ready = 1'b1;
    cyc();
    send(2'b11, PC, FRAME);
    check("mr_reload", o_data, PC);
    check("mr_rmode", W'(o_mode), W'(2'b11));
    idle();

    g4 = 64'h01234567_A5C30F1E;
    for (int b = 0; b < 10; b++) begin
      v4 = 1'b1;
      md4 = (b == 0);
      d4 = '0;
      if (b >= 2) begin
        d4[3:0] = g4[28 - 4*(b-2) +: 4];
        d4[7:4] = g4[60 - 4*(b-2) +: 4];
      end
      if (b == 9)
        check("d4_early", W'(ov4), '0);
      cyc();
    end
    check("d4_valid", W'(ov4), W'(1));
    check("d4_data", W'(od4), W'(g4));
    check("d4_mode", W'(om4), W'(2'b10));
    v4 = 1'b0;
    cyc();
    check("d4_pulse", W'(ov4), '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
